// File: rtl/aha_clk_rst_req_seq.sv
// Purpose: sequences clock-gate / reset-assert / reset-release / clock-ungate for one gated domain.
// Latency: state moves on the edge that samples a pulse; outputs follow one edge later (registered).
// Backpressure: none; pulses arriving mid-sequence are held as pending release/request flags.
module aha_clk_rst_req_seq #(
  parameter int GATE_CYCLES    = 4,
  parameter int MIN_RST_CYCLES = 3,
  parameter int HOLD_CYCLES    = 8
) (
  input  logic CLK,
  input  logic RESET,
  input  logic RISE_PULSE,
  input  logic FALL_PULSE,
  output logic CLKEN_OUT,
  output logic RST_OUT,
  output logic ACK,
  output logic BUSY,
  output logic PROTO_ERR
);

  localparam int MAX_GR  = (GATE_CYCLES > MIN_RST_CYCLES) ? GATE_CYCLES : MIN_RST_CYCLES;
  localparam int MAX_ALL = (MAX_GR > HOLD_CYCLES) ? MAX_GR : HOLD_CYCLES;
  localparam int CW      = $clog2(MAX_ALL + 1);

  localparam logic [CW-1:0] GATE_LAST = CW'(GATE_CYCLES - 1);
  localparam logic [CW-1:0] RST_LAST  = CW'(MIN_RST_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_RUN  = 3'd0,
    S_GATE = 3'd1,
    S_RST  = 3'd2,
    S_HELD = 3'd3,
    S_REL  = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            r_rel_pend;
  logic            w_rel_pend_nxt;
  logic            r_req_pend;
  logic            w_req_pend_nxt;
  logic            r_proto_seen;

  logic            w_rise;
  logic            w_fall;
  logic            w_both;

  logic            w_clken;
  logic            w_rst;
  logic            w_ack;
  logic            w_busy;

  logic            r_clken;
  logic            r_rst;
  logic            r_ack;
  logic            r_busy;
  logic            r_proto_err;

  // A simultaneous rise/fall pair is a protocol violation; neither pulse is acted on.
  assign w_both = RISE_PULSE & FALL_PULSE;
  assign w_rise = RISE_PULSE & ~FALL_PULSE;
  assign w_fall = FALL_PULSE & ~RISE_PULSE;

  // State, counter, pending flags and sticky protocol-error capture.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state      <= S_RUN;
      r_cnt        <= '0;
      r_rel_pend   <= 1'b0;
      r_req_pend   <= 1'b0;
      r_proto_seen <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_rel_pend   <= w_rel_pend_nxt;
      r_req_pend   <= w_req_pend_nxt;
      r_proto_seen <= r_proto_seen | w_both;
    end
  end

  // Next state and pending-flag bookkeeping; the counter restarts on every state change.
  always_comb begin
    w_state_nxt    = r_state;
    w_rel_pend_nxt = r_rel_pend;
    w_req_pend_nxt = r_req_pend;
    case (r_state)
      S_RUN: begin
        if (w_rise) w_state_nxt = S_GATE;
      end
      S_GATE: begin
        if (w_fall) w_rel_pend_nxt = 1'b1;
        if (w_rise) w_rel_pend_nxt = 1'b0;
        if (r_cnt == GATE_LAST) w_state_nxt = S_RST;
      end
      S_RST: begin
        if (w_fall) w_rel_pend_nxt = 1'b1;
        if (w_rise) w_rel_pend_nxt = 1'b0;
        if (r_cnt == RST_LAST) w_state_nxt = S_HELD;
      end
      S_HELD: begin
        if (w_rise) w_rel_pend_nxt = 1'b0;
        if (r_rel_pend || w_fall) begin
          w_state_nxt    = S_REL;
          w_rel_pend_nxt = 1'b0;
        end
      end
      S_REL: begin
        if (w_rise) w_req_pend_nxt = 1'b1;
        if (w_fall) w_req_pend_nxt = 1'b0;
        // A re-request landing on the final REL cycle still counts.
        if (r_cnt == HOLD_LAST) begin
          w_state_nxt    = w_req_pend_nxt ? S_GATE : S_RUN;
          w_req_pend_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt    = S_RUN;
        w_rel_pend_nxt = 1'b0;
        w_req_pend_nxt = 1'b0;
      end
    endcase

    if (w_state_nxt != r_state) begin
      w_cnt_nxt = '0;
    end else if (r_state == S_GATE || r_state == S_RST || r_state == S_REL) begin
      w_cnt_nxt = r_cnt + CW'(1);
    end else begin
      w_cnt_nxt = '0;
    end
  end

  // Per-state output levels, registered below so they lag the state by one edge.
  always_comb begin
    w_clken = 1'b0;
    w_rst   = 1'b0;
    w_ack   = 1'b0;
    w_busy  = 1'b0;
    case (r_state)
      S_RUN:  w_clken = 1'b1;
      S_GATE: w_busy  = 1'b1;
      S_RST: begin
        w_rst  = 1'b1;
        w_busy = 1'b1;
      end
      S_HELD: begin
        w_rst = 1'b1;
        w_ack = 1'b1;
      end
      S_REL: begin
        w_ack  = 1'b1;
        w_busy = 1'b1;
      end
      default: w_clken = 1'b1;
    endcase
  end

  // Output registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_clken     <= 1'b1;
      r_rst       <= 1'b0;
      r_ack       <= 1'b0;
      r_busy      <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      r_clken     <= w_clken;
      r_rst       <= w_rst;
      r_ack       <= w_ack;
      r_busy      <= w_busy;
      r_proto_err <= r_proto_seen;
    end
  end

  assign CLKEN_OUT = r_clken;
  assign RST_OUT   = r_rst;
  assign ACK       = r_ack;
  assign BUSY      = r_busy;
  assign PROTO_ERR = r_proto_err;

endmodule

// File: tb/tb_aha_clk_rst_req_seq.sv
// Purpose: directed bench for aha_clk_rst_req_seq with hand-computed output vectors.
// Latency: outputs sampled 1 time unit after each rising edge; edge numbers count from reset release.
// Backpressure: not applicable; pulses are driven as one-cycle strobes.
module tb_aha_clk_rst_req_seq;

  logic clk;
  logic reset;
  logic rise_pulse;
  logic fall_pulse;
  logic clken_out;
  logic rst_out;
  logic ack;
  logic busy;
  logic proto_err;

  int n_checks;
  int n_errors;
  int ecnt;

  logic [3:0] outs;
  assign outs = {clken_out, rst_out, ack, busy};

  aha_clk_rst_req_seq #(
    .GATE_CYCLES   (4),
    .MIN_RST_CYCLES(3),
    .HOLD_CYCLES   (8)
  ) dut (
    .CLK       (clk),
    .RESET     (reset),
    .RISE_PULSE(rise_pulse),
    .FALL_PULSE(fall_pulse),
    .CLKEN_OUT (clken_out),
    .RST_OUT   (rst_out),
    .ACK       (ack),
    .BUSY      (busy),
    .PROTO_ERR (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at edge %0d: got %h expected %h", tag, ecnt, obs, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    ecnt++;
  endtask

  task automatic run_to(input int n);
    while (ecnt < n) step();
  endtask

  // Drive a pulse so that it is sampled on edge n.
  task automatic pulse(input logic r, input logic f, input int n);
    run_to(n - 1);
    rise_pulse = r;
    fall_pulse = f;
    step();
    rise_pulse = 1'b0;
    fall_pulse = 1'b0;
  endtask

  // Check {CLKEN,RST,ACK,BUSY} after edge n.
  task automatic expect_at(input string tag, input int n, input logic [3:0] exp);
    run_to(n);
    check(tag, {28'd0, outs}, {28'd0, exp});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    ecnt = 0;
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    ecnt       = 0;
    reset      = 1'b0;
    rise_pulse = 1'b0;
    fall_pulse = 1'b0;

    // Reset state
    do_reset();
    check("rst_outs", {28'd0, outs}, 32'h8);
    check("rst_perr", {31'd0, proto_err}, 32'd0);

    // Basic cycle, with a FALL in RUN that must be ignored
    pulse(1'b0, 1'b1, 5);
    expect_at("basic_run_fall", 8, 4'b1000);
    pulse(1'b1, 1'b0, 10);
    check("basic_e10", {28'd0, outs}, 32'h8);
    expect_at("basic_gate0", 11, 4'b0001);
    expect_at("basic_gate3", 14, 4'b0001);
    expect_at("basic_rst0", 15, 4'b0101);
    expect_at("basic_rst2", 17, 4'b0101);
    expect_at("basic_held", 18, 4'b0110);
    pulse(1'b0, 1'b1, 30);
    check("basic_e30", {28'd0, outs}, 32'h6);
    expect_at("basic_rel0", 31, 4'b0011);
    expect_at("basic_rel7", 38, 4'b0011);
    expect_at("basic_run", 39, 4'b1000);

    // Early release: FALL during GATE
    do_reset();
    pulse(1'b1, 1'b0, 10);
    pulse(1'b0, 1'b1, 12);
    expect_at("early_rst", 15, 4'b0101);
    expect_at("early_rst2", 17, 4'b0101);
    expect_at("early_held", 18, 4'b0110);
    expect_at("early_rel", 19, 4'b0011);
    expect_at("early_rel7", 26, 4'b0011);
    expect_at("early_run", 27, 4'b1000);

    // Cancelled release: RISE in GATE clears the pending release
    do_reset();
    pulse(1'b1, 1'b0, 10);
    pulse(1'b0, 1'b1, 12);
    pulse(1'b1, 1'b0, 14);
    expect_at("cancel_held", 18, 4'b0110);
    expect_at("cancel_held19", 19, 4'b0110);
    expect_at("cancel_held25", 25, 4'b0110);
    pulse(1'b0, 1'b1, 30);
    expect_at("cancel_rel", 31, 4'b0011);
    expect_at("cancel_run", 39, 4'b1000);

    // Re-request during REL
    do_reset();
    pulse(1'b1, 1'b0, 10);
    pulse(1'b0, 1'b1, 30);
    pulse(1'b1, 1'b0, 33);
    expect_at("rereq_rel7", 38, 4'b0011);
    expect_at("rereq_gate", 39, 4'b0001);
    expect_at("rereq_gate3", 42, 4'b0001);
    expect_at("rereq_rst", 43, 4'b0101);
    expect_at("rereq_rst2", 45, 4'b0101);
    expect_at("rereq_held", 46, 4'b0110);
    pulse(1'b0, 1'b1, 50);
    expect_at("rereq_rel", 51, 4'b0011);

    // Re-request withdrawn by FALL during REL
    do_reset();
    pulse(1'b1, 1'b0, 10);
    pulse(1'b0, 1'b1, 30);
    pulse(1'b1, 1'b0, 33);
    pulse(1'b0, 1'b1, 35);
    expect_at("withdraw_run", 39, 4'b1000);
    expect_at("withdraw_run42", 42, 4'b1000);

    // Simultaneous pulses
    do_reset();
    pulse(1'b1, 1'b1, 10);
    check("simul_perr10", {31'd0, proto_err}, 32'd0);
    expect_at("simul_e11", 11, 4'b1000);
    check("simul_perr11", {31'd0, proto_err}, 32'd1);
    expect_at("simul_e20", 20, 4'b1000);
    pulse(1'b1, 1'b0, 25);
    expect_at("simul_gate", 26, 4'b0001);
    check("simul_perr_sticky", {31'd0, proto_err}, 32'd1);
    do_reset();
    check("simul_perr_clr", {31'd0, proto_err}, 32'd0);

    // Reset mid-sequence
    pulse(1'b1, 1'b0, 10);
    expect_at("midrst_rst", 15, 4'b0101);
    reset = 1'b1;
    step();
    reset = 1'b0;
    expect_at("midrst_e17", 17, 4'b1000);
    pulse(1'b0, 1'b1, 20);
    expect_at("midrst_fall", 21, 4'b1000);
    expect_at("midrst_fall25", 25, 4'b1000);
    pulse(1'b1, 1'b0, 30);
    expect_at("midrst_again", 31, 4'b0001);
    expect_at("midrst_again_rst", 35, 4'b0101);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Invariant: clock enable and reset are never both asserted.
  always @(negedge clk) begin
    if (!reset && clken_out && rst_out) begin
      check("clken_rst_overlap", {30'd0, clken_out, rst_out}, 32'd2);
    end
  end

endmodule
